alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  operation request; sampled only in IDLE or DONE.
REQ-005 opcode  input  4  operation select per REQ-012.
REQ-006 dataout_A  input  WIDTH  operand A from register-file read port A.
REQ-007 dataout_B  input  WIDTH  operand B from register-file read port B.
REQ-008 ALU_IN  output  WIDTH  registered result; feeds the register-file write mux.
REQ-009 flags  output  4  registered {V,S,C,Z}.
REQ-010 busy  output  1  high while state is EXEC or MUL.
REQ-011 done  output  1  one-cycle pulse; ALU_IN/flags valid in the same cycle.

Function
REQ-012 Opcodes SHALL be: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 INC A; 7 DEC A; 8 SHL A; 9 SHR A (logical); A MUL (low WIDTH bits of A*B); B CMP (flags of A-B, ALU_IN unchanged); C PASS B; D-F reserved.
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, DONE.
REQ-014 IDLE or DONE with start=1: latch opcode, A, B; go to MUL if opcode=A, else EXEC. Without start: DONE->IDLE, IDLE holds.
REQ-015 EXEC SHALL last one cycle, then go to DONE, writing ALU_IN/flags on that edge.
REQ-016 MUL SHALL run a shift-add sequence with 3-bit counter 0..7 (one bit per cycle), then go to DONE, writing on the edge where counter=7.
REQ-017 Latency: accept at edge N; non-MUL result and done at edge N+1; MUL result and done at edge N+8.
REQ-018 done SHALL be high exactly in DONE; back-to-back non-MUL ops complete every 2 cycles.
REQ-019 start while busy SHALL be ignored; operand/opcode changes after accept SHALL NOT affect the result.
REQ-020 Arithmetic wraps modulo 2^WIDTH; Z = (result==0); S = result MSB.
REQ-021 ADD/INC: C = carry-out; SUB/DEC/CMP: C = unsigned borrow; V = signed overflow for ADD/SUB/INC/DEC/CMP.
REQ-022 SHL: C = A[MSB]; SHR: C = A[0]; AND/OR/XOR/NOT/PASS: C=0; V=0 for all non-arithmetic ops.
REQ-023 MUL: C = (high WIDTH bits of product != 0), V=0.
REQ-024 Reserved opcodes: ALU_IN and flags unchanged, EXEC path used, done still pulses.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, ALU_IN=0, flags=0, done=0, busy=0, counter and partial product=0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse; first accept is possible on the first rising edge after rst_n rises.

Structure
REQ-027 Shared package alu_pkg SHALL hold opcode constants, state encoding, flag bit indices and the WIDTH default.
REQ-028 Sequential multiplier SHALL be sub-module alu_mul_seq (start, operands, counter, product, finish strobe).

Verification
REQ-029 ADD 0x7F+0x01 -> ALU_IN=0x80, V=1 S=1 C=0 Z=0, done at edge N+1 for one cycle.
REQ-030 SUB 0x05-0x05 -> 0x00, Z=1 C=0; then CMP 0x03,0x05 -> ALU_IN still 0x00, C=1 S=1 Z=0.
REQ-031 MUL 0x0C*0x0D -> 0x9C C=0 with done at edge N+8; MUL 0x10*0x10 -> 0x00 Z=1 C=1.
REQ-032 During MUL assert start and change dataout_A/B and opcode -> ignored; result 0x9C unaffected.
REQ-033 rst_n low in MUL cycle 4 -> all outputs 0 at once, no done; ADD 0x01+0x02 after release -> 0x03.
REQ-034 start held high with ADD on every cycle -> accepted in DONE; done pulses every second cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute block.
//   - ALU_WIDTH : default operand/result width
//   - OP_*      : 4-bit opcode encodings (0xD..0xF reserved)
//   - alu_state_e : execute FSM state encoding
//   - FLAG_*    : bit positions inside the {V,S,C,Z} flags vector
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 8;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_INC  = 4'h6;
   localparam logic [3:0] OP_DEC  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_CMP  = 4'hB;
   localparam logic [3:0] OP_PASS = 4'hC;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StMul  = 2'd2,
      StDone = 2'd3
   } alu_state_e;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_S = 2;
   localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load operands and clear counter/partial product
//   a_i, b_i   : multiplicand, multiplier
//   cnt_o      : current step counter (0..WIDTH-1)
//   prod_o     : partial product including the current step's contribution
//   done_o     : high during the final step; prod_o then holds the full product
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic [WIDTH-1:0]              a_i,
   input  logic [WIDTH-1:0]              b_i,
   output logic [$clog2(WIDTH)-1:0]      cnt_o,
   output logic [2*WIDTH-1:0]            prod_o,
   output logic                          done_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               run_q, run_d;
   logic [2*WIDTH-1:0] prod_next;

   // Multiplicand shifts left and multiplier shifts right each step, so bit 0
   // of the multiplier always selects whether to add the aligned multiplicand.
   assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
   assign done_o    = run_q && (cnt_q == CntLast);
   assign prod_o    = prod_next;
   assign cnt_o     = cnt_q;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         prod_d   = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         prod_d   = prod_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (done_o) begin
            cnt_d = '0;
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle ALU execute stage with registered result and flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, opcode        : operation request and select (sampled in IDLE/DONE)
//   dataout_A, dataout_B : operands from register-file read ports
//   ALU_IN               : registered result to the register-file write mux
//   flags                : registered {V,S,C,Z}
//   busy                 : high in EXEC or MUL
//   done                 : high for the single DONE cycle
module alu_exec
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] dataout_A,
   input  logic [WIDTH-1:0] dataout_B,
   output logic [WIDTH-1:0] ALU_IN,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done
);

   localparam int unsigned Msb = WIDTH - 1;
   localparam int unsigned CntW = $clog2(WIDTH);

   alu_state_e         state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   alu_in_q, alu_in_d;
   logic [3:0]         flags_q, flags_d;

   logic               accept;
   logic               mul_start;
   logic [CntW-1:0]    mul_cnt;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_done;

   logic [WIDTH:0]     sum_ext, diff_ext, inc_ext, dec_ext;
   logic [WIDTH-1:0]   ex_res;
   logic               ex_c, ex_v;
   logic               ex_wr_res, ex_wr_flags;
   logic [3:0]         ex_flags;
   logic [3:0]         mul_flags;

   assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
   assign mul_start = accept && (opcode == OP_MUL);

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(mul_start),
      .a_i    (dataout_A),
      .b_i    (dataout_B),
      .cnt_o  (mul_cnt),
      .prod_o (mul_prod),
      .done_o (mul_done)
   );

   // Extra top bit carries out of ADD/INC and acts as the borrow for SUB/DEC/CMP.
   assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
   assign diff_ext = {1'b0, a_q} - {1'b0, b_q};
   assign inc_ext  = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_ext  = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      ex_res      = alu_in_q;
      ex_c        = 1'b0;
      ex_v        = 1'b0;
      ex_wr_res   = 1'b1;
      ex_wr_flags = 1'b1;
      case (op_q)
         OP_ADD: begin
            ex_res = sum_ext[WIDTH-1:0];
            ex_c   = sum_ext[WIDTH];
            ex_v   = (a_q[Msb] == b_q[Msb]) && (ex_res[Msb] != a_q[Msb]);
         end
         OP_SUB, OP_CMP: begin
            ex_res    = diff_ext[WIDTH-1:0];
            ex_c      = diff_ext[WIDTH];
            ex_v      = (a_q[Msb] != b_q[Msb]) && (ex_res[Msb] != a_q[Msb]);
            ex_wr_res = (op_q == OP_SUB);
         end
         OP_AND:  ex_res = a_q & b_q;
         OP_OR:   ex_res = a_q | b_q;
         OP_XOR:  ex_res = a_q ^ b_q;
         OP_NOT:  ex_res = ~a_q;
         OP_INC: begin
            ex_res = inc_ext[WIDTH-1:0];
            ex_c   = inc_ext[WIDTH];
            ex_v   = !a_q[Msb] && ex_res[Msb];
         end
         OP_DEC: begin
            ex_res = dec_ext[WIDTH-1:0];
            ex_c   = dec_ext[WIDTH];
            ex_v   = a_q[Msb] && !ex_res[Msb];
         end
         OP_SHL: begin
            ex_res = a_q << 1;
            ex_c   = a_q[Msb];
         end
         OP_SHR: begin
            ex_res = a_q >> 1;
            ex_c   = a_q[0];
         end
         OP_PASS: ex_res = b_q;
         // Reserved opcodes (MUL never reaches EXEC): leave result and flags as they are.
         default: begin
            ex_wr_res   = 1'b0;
            ex_wr_flags = 1'b0;
         end
      endcase
      ex_flags         = '0;
      ex_flags[FLAG_V] = ex_v;
      ex_flags[FLAG_S] = ex_res[Msb];
      ex_flags[FLAG_C] = ex_c;
      ex_flags[FLAG_Z] = (ex_res == '0);
   end

   always_comb begin
      mul_flags         = '0;
      mul_flags[FLAG_S] = mul_prod[Msb];
      mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
      mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_in_d = alu_in_q;
      flags_d  = flags_q;
      case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               op_d    = opcode;
               a_d     = dataout_A;
               b_d     = dataout_B;
               state_d = (opcode == OP_MUL) ? StMul : StExec;
            end else begin
               state_d = StIdle;
            end
         end
         StExec: begin
            if (ex_wr_res) begin
               alu_in_d = ex_res;
            end
            if (ex_wr_flags) begin
               flags_d = ex_flags;
            end
            state_d = StDone;
         end
         StMul: begin
            // The counter value is informational here; the strobe marks the last step.
            if (mul_done && (mul_cnt == CntW'(WIDTH - 1))) begin
               alu_in_d = mul_prod[WIDTH-1:0];
               flags_d  = mul_flags;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         alu_in_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         alu_in_q <= alu_in_d;
         flags_q  <= flags_d;
      end
   end

   assign ALU_IN = alu_in_q;
   assign flags  = flags_q;
   assign busy   = (state_q == StExec) || (state_q == StMul);
   assign done   = (state_q == StDone);

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against an
// arithmetic reference model of the opcode table and flag rules.
module tb_alu_exec;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   opcode;
   logic [W-1:0] dataout_A;
   logic [W-1:0] dataout_B;
   logic [W-1:0] ALU_IN;
   logic [3:0]   flags;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;
   int exp_res = 0;
   int exp_flags = 0;

   alu_exec #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opcode   (opcode),
      .dataout_A(dataout_A),
      .dataout_B(dataout_B),
      .ALU_IN   (ALU_IN),
      .flags    (flags),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   // Reference: plain integer arithmetic on the opcode table; flags = V*8+S*4+C*2+Z.
   task automatic model(input int op, input int a, input int b, input int r_in,
                        input int f_in, output int r_out, output int f_out);
      int full, sr, calc, c, v;
      bit wr_r, wr_f;
      calc = r_in; c = 0; v = 0; wr_r = 1; wr_f = 1; full = 0; sr = 0;
      case (op)
         0:  begin full = a + b; calc = full % 256; c = (full > 255) ? 1 : 0;
                   sr = sgn(a) + sgn(b); end
         1, 11: begin full = a - b; calc = (full + 256) % 256; c = (a < b) ? 1 : 0;
                   sr = sgn(a) - sgn(b); wr_r = (op == 1); end
         2:  calc = a & b;
         3:  calc = a | b;
         4:  calc = a ^ b;
         5:  calc = (~a) & 255;
         6:  begin full = a + 1; calc = full % 256; c = (full > 255) ? 1 : 0;
                   sr = sgn(a) + 1; end
         7:  begin full = a - 1; calc = (full + 256) % 256; c = (a < 1) ? 1 : 0;
                   sr = sgn(a) - 1; end
         8:  begin calc = (a * 2) % 256; c = a / 128; end
         9:  begin calc = a / 2; c = a % 2; end
         10: begin full = a * b; calc = full % 256; c = (full > 255) ? 1 : 0; end
         12: calc = b;
         default: begin wr_r = 0; wr_f = 0; end
      endcase
      if (op == 0 || op == 1 || op == 6 || op == 7 || op == 11)
         v = (sr > 127 || sr < -128) ? 1 : 0;
      r_out = wr_r ? calc : r_in;
      f_out = wr_f ? (v * 8 + ((calc >= 128) ? 4 : 0) + c * 2 + ((calc == 0) ? 1 : 0)) : f_in;
   endtask

   // Called at a negedge. Checks done/busy each cycle until the expected
   // completion edge, then result and flags. With scramble, inputs are
   // randomized while the operation is in flight.
   task automatic run_op(input int op, input int a, input int b, input bit scramble);
      int lat, nr, nf;
      lat = (op == 10) ? 8 : 1;
      model(op, a, b, exp_res, exp_flags, nr, nf);
      start     = 1'b1;
      opcode    = 4'(op);
      dataout_A = 8'(a);
      dataout_B = 8'(b);
      @(posedge clk);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         chk($sformatf("done op%0h k%0d", op, k), 32'(done), (k == lat) ? 1 : 0);
         chk($sformatf("busy op%0h k%0d", op, k), 32'(busy), (k < lat) ? 1 : 0);
         if (k < lat && scramble) begin
            start     = 1'($urandom_range(0, 1));
            opcode    = 4'($urandom);
            dataout_A = 8'($urandom);
            dataout_B = 8'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      exp_res   = nr;
      exp_flags = nf;
      chk($sformatf("result op%0h a%0h b%0h", op, a, b), 32'(ALU_IN), exp_res);
      chk($sformatf("flags op%0h a%0h b%0h", op, a, b), 32'(flags), exp_flags);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      opcode    = '0;
      dataout_A = '0;
      dataout_B = '0;
      #3;
      chk("reset ALU_IN", 32'(ALU_IN), 0);
      chk("reset flags", 32'(flags), 0);
      chk("reset done", 32'(done), 0);
      chk("reset busy", 32'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD overflow into sign bit
      run_op(0, 'h7F, 'h01, 1'b0);
      chk("add 7f+1 const result", 32'(ALU_IN), 'h80);
      chk("add 7f+1 const flags", 32'(flags), 4'b1100);

      // SUB to zero, then CMP leaves the result alone
      run_op(1, 5, 5, 1'b0);
      chk("sub zero flags", 32'(flags), 4'b0001);
      run_op(11, 3, 5, 1'b0);
      chk("cmp result kept", 32'(ALU_IN), 0);
      chk("cmp flags", 32'(flags), 4'b0110);

      // Multiplies, including one with inputs churned while in flight
      run_op(10, 'h0C, 'h0D, 1'b0);
      chk("mul 0c*0d const", 32'(ALU_IN), 'h9C);
      run_op(10, 'h10, 'h10, 1'b0);
      chk("mul 10*10 flags", 32'(flags), 4'b0011);
      run_op(10, 'h0C, 'h0D, 1'b1);
      chk("mul scrambled const", 32'(ALU_IN), 'h9C);

      // Reserved opcodes and a few boundary operands
      run_op(13, 1, 2, 1'b0);
      run_op(15, 'hFF, 'hFF, 1'b0);
      run_op(7, 0, 0, 1'b0);
      run_op(6, 'hFF, 0, 1'b0);
      run_op(8, 'h81, 0, 1'b0);
      run_op(9, 'h81, 0, 1'b0);

      @(negedge clk);
      chk("idle done", 32'(done), 0);
      chk("idle busy", 32'(busy), 0);

      // Reset during the fourth MUL cycle
      start     = 1'b1;
      opcode    = 4'hA;
      dataout_A = 8'h0C;
      dataout_B = 8'h0D;
      @(posedge clk);
      repeat (4) @(negedge clk);
      start = 1'b0;
      chk("mul busy before reset", 32'(busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort ALU_IN", 32'(ALU_IN), 0);
      chk("abort flags", 32'(flags), 0);
      chk("abort done", 32'(done), 0);
      chk("abort busy", 32'(busy), 0);
      exp_res   = 0;
      exp_flags = 0;
      @(negedge clk);
      chk("abort no done", 32'(done), 0);
      rst_n = 1'b1;
      run_op(0, 1, 2, 1'b0);
      chk("add after reset const", 32'(ALU_IN), 3);

      // start held high: accepted again in every DONE cycle
      start     = 1'b1;
      opcode    = 4'h0;
      dataout_A = 8'h11;
      dataout_B = 8'h22;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("b2b done k%0d", k), 32'(done), (k % 2 == 1) ? 1 : 0);
         if (k == 7) start = 1'b0;
      end
      exp_res   = 'h33;
      exp_flags = 0;
      chk("b2b result", 32'(ALU_IN), exp_res);
      chk("b2b flags", 32'(flags), exp_flags);
      @(negedge clk);

      // Randomized traffic
      repeat (80) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
